sel_scan_mux: RTL and testbench

- Parametrised successor to the 4:1 selector (SEL): N channels of W bits each, with a registered output.
- Two modes:
  - manual select: channel chosen by SEL_IN, as in SEL.
  - auto-scan: hardware steps through the channels round-robin, holding each for a programmable dwell count.
- Used in probe and debug paths where one shared output must be time-shared across several sources.

---
 rtl/sel_scan_mux.sv | 151 +++++++++++++++
 tb/tb_sel_scan_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sel_scan_mux.sv
// sel_scan_mux: N-channel, W-bit registered selector with manual select and
// round-robin auto-scan with a programmable dwell per channel.
// Optional build macro SEL_SKIP_MASK_EN adds a MASK input whose set bits
// make the scan skip those channels (manual select ignores MASK).
module sel_scan_mux #(
    parameter int unsigned CH      = 4,
    parameter int unsigned W       = 1,
    parameter int unsigned DWELL_W = 8,
    localparam int unsigned SELW   = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CH*W-1:0]      IN,
    input  logic [SELW-1:0]      SEL_IN,
    input  logic                 MODE,
    input  logic                 EN,
    input  logic [DWELL_W-1:0]   DWELL,
`ifdef SEL_SKIP_MASK_EN
    input  logic [CH-1:0]        MASK,
`endif
    output logic [W-1:0]         OUT,
    output logic [SELW-1:0]      CUR_SEL,
    output logic                 OUT_VALID,
    output logic                 WRAP
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_n;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_n;
    logic [DWELL_W-1:0] cnt_eff;
    logic [DWELL_W-1:0] dwell_last;
    logic [W-1:0]       out_n;
    logic [SELW-1:0]    sel_n;
    logic               valid_n;
    logic               wrap_n;
    logic [SELW-1:0]    step_sel;
    logic               step_wrap;
    logic [W-1:0]       chan [CH];

    // Unpack the flat input bus into one entry per channel
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            chan[i] = IN[i*W +: W];
        end
    end

    // Last counter value of a dwell; a zero DWELL behaves as a dwell of one
    always_comb begin
        dwell_last = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);
    end

`ifdef SEL_SKIP_MASK_EN
    // Nearest unmasked channel after CUR_SEL; wraps when the search passes CH-1
    always_comb begin
        int unsigned idx;
        step_sel  = CUR_SEL;
        step_wrap = 1'b0;
        idx       = 0;
        // Walk from the farthest candidate down so the nearest one wins;
        // the farthest (distance CH) is CUR_SEL itself, a full lap
        for (int unsigned k = CH; k >= 1; k--) begin
            idx = (32'(CUR_SEL) + k) % CH;
            if (!MASK[SELW'(idx)]) begin
                step_sel  = SELW'(idx);
                step_wrap = (32'(CUR_SEL) + k) >= CH;
            end
        end
    end
`else
    // Plain round-robin successor of CUR_SEL
    always_comb begin
        if (32'(CUR_SEL) == CH - 1) begin
            step_sel  = '0;
            step_wrap = 1'b1;
        end else begin
            step_sel  = CUR_SEL + SELW'(1);
            step_wrap = 1'b0;
        end
    end
`endif

    // Next state from EN/MODE, and the datapath values the edge will load
    always_comb begin
        state_n = ST_IDLE;
        sel_n   = CUR_SEL;
        out_n   = OUT;
        cnt_n   = '0;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        if (EN) begin
            state_n = MODE ? ST_SCAN : ST_MANUAL;
        end
        // A scan entered from another state starts with a fresh dwell
        cnt_eff = (state == ST_SCAN) ? cnt : '0;
        case (state_n)
            ST_MANUAL: begin
                // Out-of-range indices keep the current channel
                if (32'(SEL_IN) < CH) begin
                    sel_n = SEL_IN;
                end
                out_n   = chan[sel_n];
                valid_n = 1'b1;
            end
            ST_SCAN: begin
                // Dwell compared live so a shortened DWELL steps at once
                if (cnt_eff >= dwell_last) begin
                    sel_n  = step_sel;
                    wrap_n = step_wrap;
                end else begin
                    cnt_n = cnt_eff + DWELL_W'(1);
                end
                out_n   = chan[sel_n];
                valid_n = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Output and dwell registers; OUT and CUR_SEL always load together
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            OUT       <= '0;
            CUR_SEL   <= '0;
            OUT_VALID <= 1'b0;
            WRAP      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            OUT       <= out_n;
            CUR_SEL   <= sel_n;
            OUT_VALID <= valid_n;
            WRAP      <= wrap_n;
        end
    end

endmodule

// File: tb/tb_sel_scan_mux.sv
// tb_sel_scan_mux: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_sel_scan_mux;

    localparam int CH = 4;
    localparam int W  = 4;
    localparam int DW = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic [CH*W-1:0] IN;
    logic [1:0]      SEL_IN;
    logic            MODE;
    logic            EN;
    logic [DW-1:0]   DWELL;
    logic [CH-1:0]   MASK;
    logic [W-1:0]    OUT;
    logic [1:0]      CUR_SEL;
    logic            OUT_VALID;
    logic            WRAP;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    sel_scan_mux #(.CH(CH), .W(W), .DWELL_W(DW)) dut (
        .CLK(CLK), .RST(RST), .IN(IN), .SEL_IN(SEL_IN), .MODE(MODE),
        .EN(EN), .DWELL(DWELL),
`ifdef SEL_SKIP_MASK_EN
        .MASK(MASK),
`endif
        .OUT(OUT), .CUR_SEL(CUR_SEL), .OUT_VALID(OUT_VALID), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_sel, m_dwelt, m_d, m_next;
    bit       m_valid, m_wrap;
    logic [W-1:0] m_out;
    logic [CH-1:0] m_mask;
    int       live[$];

    always @(posedge CLK) begin
`ifdef SEL_SKIP_MASK_EN
        m_mask = MASK;
`else
        m_mask = '0;
`endif
        m_wrap = 0;
        if (RST) begin
            m_sel = 0; m_out = '0; m_valid = 0; m_dwelt = 0;
        end else if (!EN) begin
            m_valid = 0; m_dwelt = 0;
        end else if (!MODE) begin
            if (int'(SEL_IN) < CH) m_sel = int'(SEL_IN);
            m_out = IN[m_sel*W +: W];
            m_valid = 1; m_dwelt = 0;
        end else begin
            m_d = (DWELL == 0) ? 1 : int'(DWELL);
            m_dwelt++;
            if (m_dwelt >= m_d) begin
                m_dwelt = 0;
                live.delete();
                for (int i = 0; i < CH; i++) if (!m_mask[i]) live.push_back(i);
                if (live.size() > 0) begin
                    m_next = -1;
                    foreach (live[j]) if (m_next < 0 && live[j] > m_sel) m_next = live[j];
                    if (m_next < 0) begin
                        m_next = live[0];
                        m_wrap = 1;
                    end
                    m_sel = m_next;
                end
            end
            m_out = IN[m_sel*W +: W];
            m_valid = 1;
        end
    end

    // Compare DUT against model on every falling edge once reset has been seen
    always @(negedge CLK) begin
        if (started) begin
            check("model_out",   int'(OUT),       int'(m_out));
            check("model_sel",   int'(CUR_SEL),   m_sel);
            check("model_valid", int'(OUT_VALID), int'(m_valid));
            check("model_wrap",  int'(WRAP),      int'(m_wrap));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    int exp_sel [12] = '{0,0,1,1,1,2,2,2,3,3,3,0};
    int exp_out [12] = '{10,10,11,11,11,12,12,12,13,13,13,10};

    initial begin
        RST = 1; EN = 0; MODE = 0; SEL_IN = 0; DWELL = 0; MASK = '0; IN = '0;
        @(posedge CLK);
        started = 1;
        tick(); tick();
        check("rst_out", int'(OUT), 0);
        check("rst_sel", int'(CUR_SEL), 0);
        check("rst_valid", int'(OUT_VALID), 0);
        check("rst_wrap", int'(WRAP), 0);

        // Manual select: channels 0..3 hold 0,1,0,1
        RST = 0; EN = 1; MODE = 0;
        IN = {4'h1, 4'h0, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            SEL_IN = 2'(i);
            tick();
            check("man_out", int'(OUT), i % 2);
            check("man_sel", int'(CUR_SEL), i);
            check("man_valid", int'(OUT_VALID), 1);
        end

        // Scan with DWELL=3 starting from channel 0
        IN = {4'hD, 4'hC, 4'hB, 4'hA};
        SEL_IN = 0;
        tick();
        MODE = 1; DWELL = 3;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("scan_sel", int'(CUR_SEL), exp_sel[i]);
            check("scan_out", int'(OUT), exp_out[i]);
            check("scan_wrap", int'(WRAP), (i == 11) ? 1 : 0);
        end

        // DWELL=0 advances every cycle
        DWELL = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("d0_sel", int'(CUR_SEL), i % 4);
            check("d0_wrap", int'(WRAP), (i == 4) ? 1 : 0);
        end

        // Long dwell, then shorten to 2 with the counter at 5
        DWELL = 10;
        repeat (5) tick();
        check("long_sel", int'(CUR_SEL), 0);
        DWELL = 2;
        tick();
        check("short_sel", int'(CUR_SEL), 1);

        // Step to channel 2, then drop EN
        DWELL = 1;
        tick();
        check("pre_idle_sel", int'(CUR_SEL), 2);
        EN = 0;
        tick(); tick();
        check("idle_sel", int'(CUR_SEL), 2);
        check("idle_out", int'(OUT), 12);
        check("idle_valid", int'(OUT_VALID), 0);

        // Re-enable: full dwell on channel 2
        EN = 1; DWELL = 3;
        tick();
        check("resume_sel0", int'(CUR_SEL), 2);
        check("resume_valid", int'(OUT_VALID), 1);
        tick();
        check("resume_sel1", int'(CUR_SEL), 2);
        tick();
        check("resume_sel2", int'(CUR_SEL), 3);
        check("resume_out2", int'(OUT), 13);

        // Scan at channel 3 -> manual select 1, no wrap
        MODE = 0; SEL_IN = 1;
        tick();
        check("sw_sel", int'(CUR_SEL), 1);
        check("sw_out", int'(OUT), 11);
        check("sw_wrap", int'(WRAP), 0);

        // Reset in the middle of a scan
        MODE = 1;
        tick(); tick();
        RST = 1;
        tick();
        check("mrst_out", int'(OUT), 0);
        check("mrst_sel", int'(CUR_SEL), 0);
        check("mrst_valid", int'(OUT_VALID), 0);
        RST = 0;

`ifdef SEL_SKIP_MASK_EN
        // Skip mask: only channels 1 and 3 are scanned
        MODE = 0; SEL_IN = 0;
        tick();
        MODE = 1; DWELL = 1; MASK = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mask_sel", int'(CUR_SEL), (i % 2 == 0) ? 1 : 3);
            check("mask_wrap", int'(WRAP), (i == 2 || i == 4) ? 1 : 0);
        end
        MASK = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("allmask_sel", int'(CUR_SEL), 1);
            check("allmask_wrap", int'(WRAP), 0);
        end
        MASK = '0;
`endif

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            RST    = ($urandom % 64) == 0;
            EN     = ($urandom % 8) != 0;
            MODE   = ($urandom % 4) != 0;
            SEL_IN = 2'($urandom);
            if ($urandom % 16 == 0) DWELL = DW'($urandom % 12);
            else if ($urandom % 8 == 0) DWELL = DW'($urandom % 4);
            IN     = (CH*W)'($urandom);
            if ($urandom % 16 == 0) MASK = ($urandom % 4 == 0) ? 4'b1111 : 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
